// File: rtl/cu_issue_queue_if.sv
// Handshake/bus bundle between the issue queue, the cu datapath and the
// result consumer. master = environment side, slave = issue queue side.
interface cu_issue_queue_if #(
    parameter int DEPTH = 4,
    parameter int IW    = 19,
    parameter int DW    = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic          issue_en;
    logic          flush;
    logic [IW-1:0] cu_instr;
    logic [DW-1:0] cu_result;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [2:0]    res_op;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic [15:0]   done_cnt;

    modport master (
        output in_valid, in_instr, issue_en, flush, cu_result, res_ready,
        input  in_ready, cu_instr, res_valid, res_data, res_op,
        input  count, empty, full, done_cnt
    );

    modport slave (
        input  in_valid, in_instr, issue_en, flush, cu_result, res_ready,
        output in_ready, cu_instr, res_valid, res_data, res_op,
        output count, empty, full, done_cnt
    );
endinterface

// File: rtl/cu_issue_queue.sv
// Issue stage for the cu control unit: FIFO of instruction words, a
// registered issue slot (S1) feeding cu, and a result register (S2).
// Ports: clk, rst_n (async active-low), bus (cu_issue_queue_if.slave).
module cu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int IW    = 19,
    parameter int DW    = 8
) (
    input logic             clk,
    input logic             rst_n,
    cu_issue_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [IW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          s1_v_q, s1_v_d;
    logic [IW-1:0] cu_instr_q, cu_instr_d;
    logic          res_valid_q, res_valid_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic [2:0]    res_op_q, res_op_d;
    logic [15:0]   done_q, done_d;

    logic          full, empty, push, pop, s2_load, s1_adv;
    logic [IW-1:0] pop_word;

    // Extra MSB on each pointer distinguishes full from empty.
    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push     = bus.in_valid && !full && !bus.flush;
    assign s2_load  = s1_v_q && (!res_valid_q || bus.res_ready);
    assign s1_adv   = !s1_v_q || s2_load;
    assign pop      = !empty && bus.issue_en && s1_adv;
    assign pop_word = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        s1_v_d      = s1_v_q;
        cu_instr_d  = cu_instr_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        done_d      = done_q;

        if (push) wptr_d = wptr_q + 1'b1;

        if (pop) begin
            rptr_d = rptr_q + 1'b1;
            // NOP words are dropped here so they never reach S2.
            if (pop_word[IW-1 -: 3] == 3'b000) begin
                s1_v_d     = 1'b0;
                cu_instr_d = '0;
            end else begin
                s1_v_d     = 1'b1;
                cu_instr_d = pop_word;
            end
        end else if (s1_adv) begin
            s1_v_d     = 1'b0;
            cu_instr_d = '0;
        end

        if (s2_load) begin
            res_valid_d = 1'b1;
            res_data_d  = bus.cu_result;
            res_op_d    = cu_instr_q[IW-1 -: 3];
            if (done_q != 16'hFFFF) done_d = done_q + 16'd1;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end

        // Flush wins; result payload and done counter are left intact.
        if (bus.flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            s1_v_d      = 1'b0;
            cu_instr_d  = '0;
            res_valid_d = 1'b0;
            res_data_d  = res_data_q;
            res_op_d    = res_op_q;
            done_d      = done_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            s1_v_q      <= 1'b0;
            cu_instr_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            done_q      <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            s1_v_q      <= s1_v_d;
            cu_instr_q  <= cu_instr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            done_q      <= done_d;
        end
    end

    // Storage needs no reset: pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= bus.in_instr;
    end

    assign bus.in_ready  = !full && !bus.flush;
    assign bus.cu_instr  = cu_instr_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_op    = res_op_q;
    assign bus.count     = wptr_q - rptr_q;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.done_cnt  = done_q;
endmodule

// File: tb/tb_cu_issue_queue.sv
// Directed testbench for cu_issue_queue with a behavioural cu model
// (op 001 add, 101 and, 110 or of operand high/low bytes).
module tb_cu_issue_queue;
    logic clk = 1'b0;
    logic rst_n;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cu_issue_queue_if #(.DEPTH(4), .IW(19), .DW(8)) bus ();

    cu_issue_queue #(.DEPTH(4), .IW(19), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [7:0] cu_f(input logic [18:0] i);
        logic [7:0] a, b;
        a = i[15:8];
        b = i[7:0];
        case (i[18:16])
            3'b001:  return a + b;
            3'b010:  return a - b;
            3'b100:  return a ^ b;
            3'b101:  return a & b;
            3'b110:  return a | b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb bus.cu_result = cu_f(bus.cu_instr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.issue_en = 1'b1;
        bus.flush = 1'b0; bus.res_ready = 1'b1;
        #3;
        n_cmp++; if (bus.cu_instr !== 19'h0) begin n_err++; $display("FAIL rst_cu_instr got %h want 0", bus.cu_instr); end
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got %b want 0", bus.res_valid); end
        n_cmp++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_err++; $display("FAIL rst_occ got cnt=%0d e=%b f=%b want 0/1/0", bus.count, bus.empty, bus.full); end
        n_cmp++; if (bus.done_cnt !== 16'd0 || bus.res_data !== 8'h00 || bus.res_op !== 3'b000) begin n_err++; $display("FAIL rst_res got done=%0d d=%h op=%b want 0", bus.done_cnt, bus.res_data, bus.res_op); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.res_valid !== 1'b0 || bus.count !== 3'd0) begin n_err++; $display("FAIL rst_idle got rv=%b cnt=%0d want 0/0", bus.res_valid, bus.count); end
    endtask

    task automatic test_basic_add();
        bus.in_valid = 1'b1; bus.in_instr = 19'h11234;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.count !== 3'd1 || bus.cu_instr !== 19'h0) begin n_err++; $display("FAIL add_e1 got cnt=%0d cu=%h want 1/0", bus.count, bus.cu_instr); end
        tick();
        n_cmp++; if (bus.cu_instr !== 19'h11234 || bus.res_valid !== 1'b0) begin n_err++; $display("FAIL add_issue got cu=%h rv=%b want 11234/0", bus.cu_instr, bus.res_valid); end
        tick();
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h46 || bus.res_op !== 3'b001) begin n_err++; $display("FAIL add_res got rv=%b d=%h op=%b want 1/46/001", bus.res_valid, bus.res_data, bus.res_op); end
        n_cmp++; if (bus.done_cnt !== 16'd1) begin n_err++; $display("FAIL add_done got %0d want 1", bus.done_cnt); end
        tick();
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL add_clear got rv=%b want 0", bus.res_valid); end
    endtask

    task automatic test_back_to_back();
        bus.in_valid = 1'b1; bus.in_instr = 19'h50F0F;
        tick();
        bus.in_instr = 19'h00000;
        tick();
        bus.in_instr = 19'h6F00F;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h0F) begin n_err++; $display("FAIL b2b_and got rv=%b d=%h want 1/0f", bus.res_valid, bus.res_data); end
        tick();
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL b2b_bubble got rv=%b want 0", bus.res_valid); end
        tick();
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'hFF || bus.res_op !== 3'b110) begin n_err++; $display("FAIL b2b_or got rv=%b d=%h op=%b want 1/ff/110", bus.res_valid, bus.res_data, bus.res_op); end
        tick();
        n_cmp++; if (bus.res_valid !== 1'b0 || bus.done_cnt !== 16'd3) begin n_err++; $display("FAIL b2b_end got rv=%b done=%0d want 0/3", bus.res_valid, bus.done_cnt); end
    endtask

    task automatic test_full();
        logic [18:0] w;
        logic [7:0] k8;
        bus.issue_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            k8 = 8'(i + 1);
            w = {3'b001, k8, k8};
            bus.in_valid = 1'b1; bus.in_instr = w;
            n_cmp++; if (bus.in_ready !== (i < 4 ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL full_ready[%0d] got %b want %b", i, bus.in_ready, (i < 4)); end
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.count !== 3'd4 || bus.full !== 1'b1 || bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_state got cnt=%0d f=%b rdy=%b want 4/1/0", bus.count, bus.full, bus.in_ready); end
        bus.issue_en = 1'b1;
        tick();
        n_cmp++; if (bus.count !== 3'd3 || bus.res_valid !== 1'b0) begin n_err++; $display("FAIL full_pop1 got cnt=%0d rv=%b want 3/0", bus.count, bus.res_valid); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'(2 * (k + 1))) begin n_err++; $display("FAIL full_res[%0d] got rv=%b d=%h want 1/%h", k, bus.res_valid, bus.res_data, 8'(2 * (k + 1))); end
        end
        tick();
        n_cmp++; if (bus.res_valid !== 1'b0 || bus.empty !== 1'b1 || bus.done_cnt !== 16'd7) begin n_err++; $display("FAIL full_end got rv=%b e=%b done=%0d want 0/1/7", bus.res_valid, bus.empty, bus.done_cnt); end
    endtask

    task automatic test_backpressure();
        bus.res_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 19'h10102;
        tick();
        bus.in_instr = 19'h10304;
        tick();
        bus.in_instr = 19'h10506;
        tick();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h03 || bus.cu_instr !== 19'h10304 || bus.count !== 3'd1) begin n_err++; $display("FAIL bp_hold[%0d] got rv=%b d=%h cu=%h cnt=%0d want 1/03/10304/1", c, bus.res_valid, bus.res_data, bus.cu_instr, bus.count); end
            if (c < 2) tick();
        end
        bus.res_ready = 1'b1;
        tick();
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h07 || bus.cu_instr !== 19'h10506) begin n_err++; $display("FAIL bp_res2 got rv=%b d=%h cu=%h want 1/07/10506", bus.res_valid, bus.res_data, bus.cu_instr); end
        tick();
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h0B) begin n_err++; $display("FAIL bp_res3 got rv=%b d=%h want 1/0b", bus.res_valid, bus.res_data); end
        tick();
        n_cmp++; if (bus.res_valid !== 1'b0 || bus.done_cnt !== 16'd10) begin n_err++; $display("FAIL bp_end got rv=%b done=%0d want 0/10", bus.res_valid, bus.done_cnt); end
    endtask

    task automatic test_flush();
        bus.res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1; bus.in_instr = 19'h11011 + 19'(k);
            tick();
        end
        n_cmp++; if (bus.count !== 3'd3 || bus.res_valid !== 1'b1 || bus.res_data !== 8'h21) begin n_err++; $display("FAIL fl_pre got cnt=%0d rv=%b d=%h want 3/1/21", bus.count, bus.res_valid, bus.res_data); end
        bus.in_instr = 19'h17777; bus.flush = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready got %b want 0", bus.in_ready); end
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        n_cmp++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.res_valid !== 1'b0 || bus.cu_instr !== 19'h0) begin n_err++; $display("FAIL fl_clear got cnt=%0d e=%b rv=%b cu=%h want 0/1/0/0", bus.count, bus.empty, bus.res_valid, bus.cu_instr); end
        n_cmp++; if (bus.res_data !== 8'h21 || bus.res_op !== 3'b001 || bus.done_cnt !== 16'd11) begin n_err++; $display("FAIL fl_keep got d=%h op=%b done=%0d want 21/001/11", bus.res_data, bus.res_op, bus.done_cnt); end
        bus.res_ready = 1'b1;
        repeat (3) tick();
        n_cmp++; if (bus.res_valid !== 1'b0 || bus.count !== 3'd0 || bus.done_cnt !== 16'd11) begin n_err++; $display("FAIL fl_after got rv=%b cnt=%0d done=%0d want 0/0/11", bus.res_valid, bus.count, bus.done_cnt); end
    endtask

    task automatic test_async_reset();
        bus.in_valid = 1'b1; bus.in_instr = 19'h10203;
        tick();
        bus.in_instr = 19'h10405;
        tick();
        bus.in_valid = 1'b0;
        tick();
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h05 || bus.cu_instr !== 19'h10405 || bus.done_cnt !== 16'd12) begin n_err++; $display("FAIL ar_pre got rv=%b d=%h cu=%h done=%0d want 1/05/10405/12", bus.res_valid, bus.res_data, bus.cu_instr, bus.done_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.res_valid !== 1'b0 || bus.cu_instr !== 19'h0 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin n_err++; $display("FAIL ar_async got rv=%b cu=%h cnt=%0d e=%b want 0/0/0/1", bus.res_valid, bus.cu_instr, bus.count, bus.empty); end
        n_cmp++; if (bus.done_cnt !== 16'd0 || bus.res_data !== 8'h00 || bus.res_op !== 3'b000) begin n_err++; $display("FAIL ar_async_res got done=%0d d=%h op=%b want 0/00/000", bus.done_cnt, bus.res_data, bus.res_op); end
        #1 rst_n = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = 19'h10101;
        tick();
        bus.in_valid = 1'b0;
        tick();
        n_cmp++; if (bus.cu_instr !== 19'h10101 || bus.res_valid !== 1'b0) begin n_err++; $display("FAIL ar_issue got cu=%h rv=%b want 10101/0", bus.cu_instr, bus.res_valid); end
        tick();
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h02 || bus.done_cnt !== 16'd1) begin n_err++; $display("FAIL ar_res got rv=%b d=%h done=%0d want 1/02/1", bus.res_valid, bus.res_data, bus.done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_back_to_back();
        test_full();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
